// File: rtl/audio_pkg.sv
// Shared types and helpers for the PWM audio player.
// Holds the FSM state encoding, MMIO address and PCM->duty mapping.
package audio_pkg;

  localparam logic [31:0] AUDIO_ADDR = 32'h2000;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY
  } play_state_t;

  // Signed PCM to offset-binary duty: flip sign, keep top 7 magnitude bits.
  function automatic logic [7:0] sample_to_duty(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered read data (valid cycle after pop).
// Ports: clock, reset (async low), push/din, pop/dout, count, full, empty.
module sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [15:0]              din,
  input  logic                     pop,
  output logic [15:0]              dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   dout_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // Full/empty are judged on the registered count: no bypass either way.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) begin
        rd_q   <= rd_q + AW'(1);
        dout_q <= mem_q[rd_q];
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = dout_q;
  assign count = cnt_q;

endmodule

// File: rtl/audio_pwm_player.sv
// Buffered PCM player: FIFO, sample-rate divider, 8-bit PWM, sticky flags.
// Ports: clock/reset, enable, audio_data/data_valid, clr_status, status, audioOut.
module audio_pwm_player
  import audio_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 8000,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 4,
  parameter int SAMPLE_DIV  = CLK_HZ / SAMPLE_HZ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   audio_data,
  input  logic                          data_valid,
  input  logic                          clr_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          underrun,
  output logic                          overflow,
  output logic                          playing,
  output logic                          audioOut
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  play_state_t   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    pwm_q, pwm_d;
  logic [7:0]    duty_q, duty_d;
  logic          aout_q, aout_d;
  logic          pop_q;
  logic          und_q, ovf_q;

  logic          tick, pop, empty, in_play;
  logic [15:0]   dout;

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (data_valid),
    .din   (audio_data),
    .pop   (pop),
    .dout  (dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (empty)
  );

  assign tick = (state_q == PLAY) && (tick_q == TW'(SAMPLE_DIV - 1));
  assign pop  = tick && !empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable)
          state_d = IDLE;
        else if (fifo_count >= CW'(PRIME_LEVEL))
          state_d = PLAY;
      end
      PLAY:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters run only while staying in PLAY: zero on entry and on exit.
  assign in_play = (state_q == PLAY) && (state_d == PLAY);

  always_comb begin
    tick_d = '0;
    pwm_d  = '0;
    duty_d = 8'h80;
    aout_d = 1'b0;
    if (in_play) begin
      tick_d = tick ? '0 : tick_q + TW'(1);
      pwm_d  = pwm_q + 8'd1;
      duty_d = pop_q ? sample_to_duty(dout) : duty_q;
      aout_d = (pwm_q < duty_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      pwm_q   <= '0;
      duty_q  <= 8'h80;
      aout_q  <= 1'b0;
      pop_q   <= 1'b0;
      und_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      duty_q  <= duty_d;
      aout_q  <= aout_d;
      pop_q   <= pop;
      // A new event beats a same-cycle clear.
      if (tick && empty)          und_q <= 1'b1;
      else if (clr_status)        und_q <= 1'b0;
      if (data_valid && fifo_full) ovf_q <= 1'b1;
      else if (clr_status)        ovf_q <= 1'b0;
    end
  end

  assign underrun = und_q;
  assign overflow = ovf_q;
  assign playing  = (state_q == PLAY);
  assign audioOut = aout_q;

endmodule

// File: tb/tb_audio_pwm_player.sv
// Self-checking bench for audio_pwm_player (SAMPLE_DIV forced to 8).
// Table-driven duty mapping plus scoreboarded FIFO order and corner sequences.
module tb_audio_pwm_player;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] audio_data = '0;
  logic        data_valid = 1'b0;
  logic        clr_status = 1'b0;
  logic [4:0]  fifo_count;
  logic        fifo_full, underrun, overflow, playing, audioOut;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] last_duty = 8'h80;
  logic [7:0] mon_exp;

  typedef struct {
    logic [15:0] s;
    int          highs;
  } map_t;
  map_t tbl[4];

  audio_pwm_player #(.SAMPLE_DIV(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .audio_data (audio_data),
    .data_valid (data_valid),
    .clr_status (clr_status),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .underrun   (underrun),
    .overflow   (overflow),
    .playing    (playing),
    .audioOut   (audioOut)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] s);
    audio_data = s;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic clr();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
  endtask

  task automatic wait_play(input string name);
    int k = 0;
    while (!playing && k < 20) begin
      step();
      k++;
    end
    chk(name, playing, 1);
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (fifo_count != 0 && k < 300) begin
      step();
      k++;
    end
    chk(name, fifo_count, 0);
  endtask

  // Scoreboard: each change of the played duty pops the next expected one.
  always @(negedge clock) begin
    if (mon_en && dut.duty_q != last_duty) begin
      last_duty = dut.duty_q;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL duty_extra: got %0h want none", dut.duty_q);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp != dut.duty_q) begin
          n_bad++;
          $display("FAIL duty_seq: got %0h want %0h", dut.duty_q, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    tbl[0] = '{16'h8000, 0};
    tbl[1] = '{16'h7FFF, 255};
    tbl[2] = '{16'h0000, 128};
    tbl[3] = '{16'hFFFF, 127};

    // Reset state
    #3;
    chk("rst_count", fifo_count, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_playing", playing, 0);
    chk("rst_audio", audioOut, 0);
    step(2);
    reset = 1'b1;
    step();

    // Prime, first tick latency, then underrun on the 5th tick
    enable = 1'b1;
    step();
    push(16'h1100);
    push(16'h2200);
    push(16'h3300);
    chk("prime_count3", fifo_count, 3);
    step(3);
    chk("prime_wait", playing, 0);
    last_duty = 8'h80;
    exp_q.push_back(8'h91);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hB3);
    exp_q.push_back(8'hC4);
    mon_en = 1'b1;
    push(16'h4400);
    chk("prime_count4", fifo_count, 4);
    chk("prime_not_yet", playing, 0);
    step();
    chk("prime_play", playing, 1);
    step(7);
    chk("tick_before", fifo_count, 4);
    step();
    chk("tick_first", fifo_count, 3);
    step(31);
    chk("und_before", underrun, 0);
    chk("und_empty", fifo_count, 0);
    step();
    chk("und_set", underrun, 1);
    chk("und_playing", playing, 1);
    chk("und_duty_hold", dut.duty_q, 8'hC4);
    chk("und_sb_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    enable = 1'b0;
    step();
    clr();
    chk("und_clr", underrun, 0);
    chk("idle_playing", playing, 0);

    // Duty mapping table
    for (int i = 0; i < 4; i++) begin
      enable = 1'b0;
      step();
      clr();
      repeat (4) push(tbl[i].s);
      enable = 1'b1;
      wait_play($sformatf("map%0d_play", i));
      wait_empty($sformatf("map%0d_drain", i));
      step(4);
      h = 0;
      for (int c = 0; c < 256; c++) begin
        step();
        h += int'(audioOut);
      end
      chk($sformatf("map%0d_highs", i), h, tbl[i].highs);
    end
    enable = 1'b0;
    step();
    clr();

    // Overflow with playback disabled
    chk("ovf_start", fifo_count, 0);
    for (int k = 1; k <= 17; k++) push(16'(k) << 8);
    chk("ovf_count", fifo_count, 16);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_flag", overflow, 1);
    for (int k = 1; k <= 16; k++) exp_q.push_back(8'h80 + 8'(k));
    clr();
    chk("ovf_clr", overflow, 0);
    chk("ovf_kept", fifo_count, 16);

    // Push on the tick cycle: full then mid-level
    last_duty = 8'h80;
    mon_en = 1'b1;
    enable = 1'b1;
    wait_play("sim_play");
    step(7);
    audio_data = 16'h7700;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("sim_full_count", fifo_count, 15);
    chk("sim_full_flag", fifo_full, 0);
    chk("sim_full_ovf", overflow, 1);
    step(63);
    chk("sim_mid_before", fifo_count, 8);
    exp_q.push_back(8'hD5);
    audio_data = 16'h5500;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("sim_mid_count", fifo_count, 8);
    step(8);
    chk("sim_next_pop", fifo_count, 7);
    wait_empty("sim_drain");
    step(4);
    chk("sim_sb_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset in the middle of playback
    enable = 1'b0;
    step();
    repeat (10) push(16'h0100);
    enable = 1'b1;
    wait_play("rmp_play");
    step(3);
    chk("rmp_count", fifo_count, 10);
    chk("rmp_ovf", overflow, 1);
    chk("rmp_audio", audioOut, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rmp_audio0", audioOut, 0);
    chk("rmp_count0", fifo_count, 0);
    chk("rmp_idle", playing, 0);
    chk("rmp_ovf0", overflow, 0);
    chk("rmp_full0", fifo_full, 0);
    enable = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    chk("rel_ovf", overflow, 0);
    chk("rel_und", underrun, 0);
    chk("rel_count", fifo_count, 0);
    chk("rel_playing", playing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
